// File: rtl/bert_pkg.sv
// Shared types and constants for the BERT test sequencer: FSM state encoding,
// PRBS-8 geometry and taps (fb = r[6]^r[5]^r[0]), lock-up-safe default seed.
package bert_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SYNC,
        RUN,
        DONE
    } state_t;

    localparam int                PRBS_W            = 8;
    localparam logic [PRBS_W-1:0] PRBS_TAPS         = 8'b0110_0001;
    localparam logic [PRBS_W-1:0] PRBS_SEED_DEFAULT = 8'h0F;
    localparam int                RESYNC_W          = 8;

    function automatic logic prbs_fb(input logic [PRBS_W-1:0] r);
        return ^(r & PRBS_TAPS);
    endfunction

endpackage

// File: rtl/bert_seq_ctrl_if.sv
// Host/config and TX/RX line signals of the BERT sequencer, bundled with
// master (host side) and slave (sequencer side) views.
interface bert_seq_ctrl_if
    import bert_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int ERR_W = 16
);
    logic                start;
    logic [CNT_W-1:0]    num_bits;
    logic [PRBS_W-1:0]   seed;
    logic                rx_bit;
    logic                rx_valid;
    logic                tx_bit;
    logic                tx_valid;
    logic                busy;
    logic                done;
    logic                locked;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ERR_W-1:0]    err_cnt;
    logic [RESYNC_W-1:0] resync_cnt;

    modport master (
        output start, num_bits, seed, rx_bit, rx_valid,
        input  tx_bit, tx_valid, busy, done, locked, bit_cnt, err_cnt, resync_cnt
    );

    modport slave (
        input  start, num_bits, seed, rx_bit, rx_valid,
        output tx_bit, tx_valid, busy, done, locked, bit_cnt, err_cnt, resync_cnt
    );

endinterface

// File: rtl/bert_prbs_reg.sv
// 8-bit PRBS shift register with parallel load; the shift-in bit is either the
// local feedback (generator / free-running checker) or an external bit (refill).
module bert_prbs_reg
    import bert_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [PRBS_W-1:0] load_val,
    input  logic              shift_en,
    input  logic              ext_sel,
    input  logic              ext_bit,
    output logic [PRBS_W-1:0] q,
    output logic              fb
);

    logic shift_in;

    assign fb       = prbs_fb(q);
    assign shift_in = ext_sel ? ext_bit : fb;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {q[PRBS_W-2:0], shift_in};
        end
    end

endmodule

// File: rtl/bert_seq_ctrl.sv
// BERT test sequencer: seeds/runs the TX PRBS, self-syncs a checker on the
// returned stream, counts bits/errors/resyncs. Optional: BERT_ERR_INJECT_EN.
module bert_seq_ctrl
    import bert_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int ERR_W     = 16,
    parameter int LOSS_ERRS = 4
) (
    input  logic           clk,
    input  logic           reset,
`ifdef BERT_ERR_INJECT_EN
    input  logic           inject_err,
`endif
    bert_seq_ctrl_if.slave bus
);

    localparam logic [3:0] LOSS_LIM = 4'(LOSS_ERRS);

    state_t              state_q, state_d;
    logic                accept, busy, done, locked, tx_valid;
    logic [CNT_W-1:0]    num_bits_q, bit_cnt_q;
    logic [ERR_W-1:0]    err_cnt_q;
    logic [RESYNC_W-1:0] resync_cnt_q;
    logic [PRBS_W-1:0]   seed_q, seed_eff, tx_q, chk_q;
    logic [2:0]          sync_cnt_q, blk_idx_q;
    logic [3:0]          blk_err_q, blk_err_sum;
    logic                tx_fb, pred, rx_fire, rx_err, bit_last, blk_loss, tx_flip;
    logic                unused_q;

    assign seed_eff    = (bus.seed == '0) ? PRBS_SEED_DEFAULT : bus.seed;
    assign rx_fire     = bus.rx_valid && (state_q == SYNC || state_q == RUN);
    assign rx_err      = bus.rx_bit ^ pred;
    assign bit_last    = (bit_cnt_q + CNT_W'(1)) == num_bits_q;
    // Error tally restarts on the first bit of every 8-bit block.
    assign blk_err_sum = ((blk_idx_q == 3'd0) ? 4'd0 : blk_err_q) + {3'd0, rx_err};
    assign blk_loss    = blk_err_sum >= LOSS_LIM;
    assign unused_q    = ^{tx_q, chk_q};

`ifdef BERT_ERR_INJECT_EN
    assign tx_flip = inject_err;
`else
    assign tx_flip = 1'b0;
`endif

    bert_prbs_reg u_tx_prbs (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == LOAD),
        .load_val (seed_q),
        .shift_en (tx_valid),
        .ext_sel  (1'b0),
        .ext_bit  (1'b0),
        .q        (tx_q),
        .fb       (tx_fb)
    );

    // Checker takes the line bit while syncing, then free-runs on its own prediction.
    bert_prbs_reg u_chk_prbs (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .shift_en (rx_fire),
        .ext_sel  (state_q == SYNC),
        .ext_bit  (bus.rx_bit),
        .q        (chk_q),
        .fb       (pred)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output is defaulted first, so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        locked   = 1'b0;
        tx_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = (bus.num_bits == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = SYNC;
            end
            SYNC: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                if (rx_fire && sync_cnt_q == 3'd7) state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                locked   = 1'b1;
                if (rx_fire) begin
                    if (bit_last)      state_d = DONE;
                    else if (blk_loss) state_d = SYNC;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            num_bits_q   <= '0;
            seed_q       <= '0;
            bit_cnt_q    <= '0;
            err_cnt_q    <= '0;
            resync_cnt_q <= '0;
            sync_cnt_q   <= '0;
            blk_idx_q    <= '0;
            blk_err_q    <= '0;
        end else begin
            if (accept) begin
                num_bits_q   <= bus.num_bits;
                seed_q       <= seed_eff;
                bit_cnt_q    <= '0;
                err_cnt_q    <= '0;
                resync_cnt_q <= '0;
            end
            // Wraps to 0 after the 8th refill bit, so every SYNC entry starts clean.
            if (state_q == SYNC && rx_fire) sync_cnt_q <= sync_cnt_q + 3'd1;
            if (state_q != RUN)  blk_idx_q <= '0;
            else if (rx_fire)    blk_idx_q <= blk_idx_q + 3'd1;
            if (state_q == RUN && rx_fire) begin
                blk_err_q <= blk_err_sum;
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                if (rx_err && err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
                if (blk_loss && !bit_last && resync_cnt_q != '1)
                    resync_cnt_q <= resync_cnt_q + RESYNC_W'(1);
            end
        end
    end

    assign bus.tx_bit     = tx_valid & (tx_fb ^ tx_flip);
    assign bus.tx_valid   = tx_valid;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.locked     = locked;
    assign bus.bit_cnt    = bit_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.resync_cnt = resync_cnt_q;

endmodule

// File: tb/tb_bert_seq_ctrl.sv
// Directed loopback bench for bert_seq_ctrl: rx is tx with an optional bit flip.
module tb_bert_seq_ctrl;
    import bert_pkg::*;

    localparam int CNT_W = 32;
    localparam int ERR_W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flip  = 1'b0;
`ifdef BERT_ERR_INJECT_EN
    logic inject_err = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;
    int t_start  = 0;

    bert_seq_ctrl_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

    assign bus.rx_bit   = bus.tx_bit ^ flip;
    assign bus.rx_valid = bus.tx_valid;

    bert_seq_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W), .LOSS_ERRS(4)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef BERT_ERR_INJECT_EN
        .inject_err (inject_err),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic logic [15:0] model_bits(input logic [7:0] seed);
        logic [7:0]  r;
        logic        b;
        logic [15:0] bits;
        r = seed;
        bits = '0;
        for (int i = 0; i < 16; i++) begin
            b = r[6] ^ r[5] ^ r[0];
            bits[15-i] = b;
            r = {r[6:0], b};
        end
        return bits;
    endfunction

    task automatic start_test(input logic [CNT_W-1:0] n, input logic [7:0] s);
        bus.start    = 1'b1;
        bus.num_bits = n;
        bus.seed     = s;
        t_start      = cycle;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic capture_tx(output logic [15:0] bits);
        bits = '0;
        for (int i = 0; i < 16; i++) begin
            bits[15-i] = bus.tx_bit;
            tick();
        end
    endtask

    task automatic wait_locked(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.locked && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_lock"}, bus.locked, 1'b1);
    endtask

    task automatic wait_done(input string tag, input int budget, input int exp_lat);
        int n;
        n = 0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, bus.done, 1'b1);
        check({tag, "_latency"}, cycle - t_start, exp_lat);
    endtask

    task automatic check_counts(input string tag, input int bits, input int errs, input int rs);
        check({tag, "_bit_cnt"}, bus.bit_cnt, bits);
        check({tag, "_err_cnt"}, bus.err_cnt, errs);
        check({tag, "_resync_cnt"}, bus.resync_cnt, rs);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
        check({tag, "_locked"}, bus.locked, 1'b0);
        check({tag, "_tx_valid"}, bus.tx_valid, 1'b0);
        check({tag, "_tx_bit"}, bus.tx_bit, 1'b0);
        check_counts(tag, 0, 0, 0);
    endtask

    initial begin
        logic [15:0] bits;
        int          saved;

        bus.start    = 1'b0;
        bus.num_bits = '0;
        bus.seed     = '0;

        // Reset state
        reset = 1'b0;
        repeat (2) tick();
        check_all_zero("rst");
        reset = 1'b1;
        tick();

        // Clean loopback, seed 0x5A: first bits 1001_0101 by hand
        start_test(1000, 8'h5A);
        check("t1_busy_t1", bus.busy, 1'b1);
        check("t1_txv_t1", bus.tx_valid, 1'b0);
        tick();
        check("t1_txv_t2", bus.tx_valid, 1'b1);
        capture_tx(bits);
        check("t1_first8", bits[15:8], 8'b1001_0101);
        check("t1_first16", bits, model_bits(8'h5A));
        wait_done("t1", 1200, 1010);
        check_counts("t1", 1000, 0, 0);
        check("t1_busy_in_done", bus.busy, 1'b0);
        check("t1_txv_in_done", bus.tx_valid, 1'b0);
        tick();
        check("t1_done_pulse", bus.done, 1'b0);
        check("t1_hold_bits", bus.bit_cnt, 1000);

        // Single inverted bit in RUN
        start_test(1000, 8'h5A);
        wait_locked("t2", 50);
        repeat (100) tick();
        flip = 1'b1;
        tick();
        flip = 1'b0;
        check("t2_still_locked", bus.locked, 1'b1);
        wait_done("t2", 1200, 1010);
        check_counts("t2", 1000, 1, 0);
        tick();

        // Four errors at block indices 0..3 of the third block force a resync
        start_test(1000, 8'h5A);
        wait_locked("t3", 50);
        check("t3_lock_cycle", cycle - t_start, 10);
        repeat (16) tick();
        flip = 1'b1;
        repeat (4) tick();
        flip = 1'b0;
        check("t3_unlocked", bus.locked, 1'b0);
        check_counts("t3_drop", 20, 4, 1);
        repeat (7) tick();
        check("t3_sync_7", bus.locked, 1'b0);
        tick();
        check("t3_relock_8", bus.locked, 1'b1);
        wait_done("t3", 1200, 1018);
        check_counts("t3", 1000, 4, 1);
        tick();

        // Zero seed behaves as 0x0F
        start_test(20, 8'h00);
        tick();
        capture_tx(bits);
        check("t4_seed0_bits", bits, model_bits(8'h0F));
        wait_done("t4", 100, 30);
        check_counts("t4", 20, 0, 0);
        tick();

        // num_bits == 0: straight to DONE, counters cleared
        start_test(0, 8'h5A);
        check("t5_done_t1", bus.done, 1'b1);
        check("t5_busy_t1", bus.busy, 1'b0);
        check_counts("t5", 0, 0, 0);
        tick();
        check("t5_done_t2", bus.done, 1'b0);
        check("t5_busy_t2", bus.busy, 1'b0);
        check("t5_txv_t2", bus.tx_valid, 1'b0);

        // Start during RUN is ignored, then reset mid-RUN
        start_test(1000, 8'h5A);
        wait_locked("t6", 50);
        repeat (50) tick();
        saved = int'(bus.bit_cnt);
        bus.start    = 1'b1;
        bus.num_bits = 5;
        bus.seed     = 8'h33;
        tick();
        bus.start    = 1'b0;
        check("t6_ign_bits", bus.bit_cnt, saved + 1);
        check("t6_ign_locked", bus.locked, 1'b1);
        tick();
        check("t6_ign_bits2", bus.bit_cnt, saved + 2);
        check("t6_ign_err", bus.err_cnt, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_all_zero("t6_rst");
        check("t6_tx_reg", dut.u_tx_prbs.q, 8'h00);
        check("t6_chk_reg", dut.u_chk_prbs.q, 8'h00);
        tick();
        check_all_zero("t6_idle");

        // Recovery run; start during DONE is ignored
        start_test(16, 8'h5A);
        wait_done("t7", 100, 26);
        check_counts("t7", 16, 0, 0);
        bus.start    = 1'b1;
        bus.num_bits = 3;
        tick();
        bus.start    = 1'b0;
        check("t7_ign_busy", bus.busy, 1'b0);
        check("t7_ign_done", bus.done, 1'b0);
        check("t7_ign_bits", bus.bit_cnt, 16);
        tick();
        check("t7_ign_busy2", bus.busy, 1'b0);

`ifdef BERT_ERR_INJECT_EN
        // One injected TX error: checker keeps tracking the true PRBS
        start_test(200, 8'h5A);
        wait_locked("t8", 50);
        repeat (20) tick();
        inject_err = 1'b1;
        tick();
        inject_err = 1'b0;
        wait_done("t8", 300, 210);
        check_counts("t8", 200, 1, 0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
